mem_arbiter: RTL and testbench

Shares the single main-memory port between the I-cache and D-cache miss paths. Each cache's fill FSM, plus the D-cache write-through path, raises a request. The arbiter grants the port to one requester for a whole transaction, forwards that requester's read/write strobes and address to memory, and routes returning data-valid pulses back to the owner. It sits between the two cache controllers and the pipelined main memory, and its grants gate the pipeline stall logic.

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Main-memory port arbiter between the I-cache and D-cache miss paths.
// Grants one cache per transaction, forwards its strobes and routes read returns back to it.
module mem_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int CNT_W   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_rd,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    input  logic        mem_data_valid,
    output logic [15:0] mem_addr,
    output logic        mem_enable,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    output logic        i_grant,
    output logic        d_grant,
    output logic        i_data_valid,
    output logic        d_data_valid,
    output logic        arb_busy
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DRAIN} state_t;

    state_t           state, state_nxt;
    logic             owner_d, owner_d_nxt;   // 1: D-cache owns the port
    logic             last_d, last_d_nxt;     // 1: D-cache was the last owner
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             rd_issue;
    logic             ret;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            owner_d <= 1'b0;
            last_d  <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            owner_d <= owner_d_nxt;
            last_d  <= last_d_nxt;
            cnt     <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_d_nxt = owner_d;
        last_d_nxt  = last_d;
        cnt_nxt     = cnt;

        // Issue and return together cancel; saturate so the count stays in [0, MEM_LAT].
        if (rd_issue && !ret) begin
            if (cnt != CNT_W'(MEM_LAT))
                cnt_nxt = cnt + CNT_W'(1);
        end else if (!rd_issue && ret) begin
            cnt_nxt = cnt - CNT_W'(1);
        end

        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    owner_d_nxt = ~last_d;
                    state_nxt   = last_d ? GNT_I : GNT_D;
                end else if (i_req) begin
                    owner_d_nxt = 1'b0;
                    state_nxt   = GNT_I;
                end else if (d_req) begin
                    owner_d_nxt = 1'b1;
                    state_nxt   = GNT_D;
                end
            end
            GNT_I: begin
                if (!i_req) begin
                    if (cnt == '0) begin
                        state_nxt  = IDLE;
                        last_d_nxt = 1'b0;
                    end else begin
                        state_nxt  = DRAIN;
                    end
                end
            end
            GNT_D: begin
                if (!d_req) begin
                    if (cnt == '0) begin
                        state_nxt  = IDLE;
                        last_d_nxt = 1'b1;
                    end else begin
                        state_nxt  = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cnt_nxt == '0) begin
                    state_nxt  = IDLE;
                    last_d_nxt = owner_d;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_enable = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            GNT_I: begin
                mem_enable = i_req & i_rd;
                mem_addr   = i_addr;
                mem_wdata  = d_wdata;
            end
            GNT_D: begin
                // A simultaneous read is dropped in favour of the write.
                mem_enable = d_req & (d_rd | d_wr);
                mem_wr     = d_req & d_wr;
                mem_addr   = d_addr;
                mem_wdata  = d_wdata;
            end
            default: ;
        endcase

        rd_issue     = mem_enable & ~mem_wr;
        ret          = mem_data_valid & (cnt != '0);
        i_grant      = (state == GNT_I) | ((state == DRAIN) & ~owner_d);
        d_grant      = (state == GNT_D) | ((state == DRAIN) &  owner_d);
        i_data_valid = ret & i_grant;
        d_data_valid = ret & d_grant;
        arb_busy     = (state != IDLE);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model and a return scoreboard.
module tb_mem_arbiter;
    localparam int MEM_LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_rd, d_req, d_rd, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        mem_data_valid;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_enable, mem_wr, i_grant, d_grant, i_data_valid, d_data_valid, arb_busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    mem_arbiter #(.MEM_LAT(MEM_LAT), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_rd(i_rd), .i_addr(i_addr),
        .d_req(d_req), .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .mem_data_valid(mem_data_valid),
        .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .i_grant(i_grant), .d_grant(d_grant),
        .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
        .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Fixed-latency memory: a read seen at an edge returns MEM_LAT cycles after its issue cycle.
    logic [MEM_LAT-1:0] pipe = '0;
    logic               stray = 1'b0;
    always @(posedge clk) pipe <= {pipe[MEM_LAT-2:0], mem_enable & ~mem_wr};
    assign mem_data_valid = pipe[MEM_LAT-1] | stray;

    typedef struct { int c; bit d; } exp_t;
    exp_t sb[$];

    task automatic expect_ret(input bit is_d);
        sb.push_back('{cyc + MEM_LAT, is_d});
    endtask

    always @(negedge clk) begin
        logic ei, ed;
        ei = 1'b0;
        ed = 1'b0;
        if (sb.size() > 0 && sb[0].c == cyc) begin
            if (sb[0].d) ed = 1'b1;
            else         ei = 1'b1;
            void'(sb.pop_front());
        end
        vectors++;
        assert (i_data_valid === ei) else begin
            miscompares++;
            $error("FAIL i_dv cyc=%0d observed=%b expected=%b", cyc, i_data_valid, ei);
        end
        vectors++;
        assert (d_data_valid === ed) else begin
            miscompares++;
            $error("FAIL d_dv cyc=%0d observed=%b expected=%b", cyc, d_data_valid, ed);
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk1 (tag, mem_enable, 1'b0);
        chk1 (tag, mem_wr, 1'b0);
        chk16(tag, mem_addr, 16'h0000);
        chk16(tag, mem_wdata, 16'h0000);
        chk1 (tag, i_grant, 1'b0);
        chk1 (tag, d_grant, 1'b0);
        chk1 (tag, i_data_valid, 1'b0);
        chk1 (tag, d_data_valid, 1'b0);
        chk1 (tag, arb_busy, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d observed=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        {i_req, i_rd, d_req, d_rd, d_wr} = '0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        #1 rst = 1'b1;
        repeat (2) step();
        chk_all_zero("reset");
        rst = 1'b0;
        for (int n = 0; n < 20; n++) begin
            step(); #1;
            chk1("idle_en", mem_enable, 1'b0);
            chk1("idle_busy", arb_busy, 1'b0);
        end

        // I-cache fill of 8 beats, with the D side toggling its strobes and address
        step(); i_req = 1'b1; #1;
        chk1("i_gnt_lat", i_grant, 1'b0);
        for (int k = 0; k < 8; k++) begin
            step();
            i_rd = 1'b1; i_addr = 16'h1230 + 16'(2 * k);
            d_rd = 1'b1; d_wr = logic'(k % 2); d_addr = 16'hA000 + 16'(k);
            expect_ret(1'b0);
            #1;
            chk1 ("i_gnt", i_grant, 1'b1);
            chk1 ("fill_en", mem_enable, 1'b1);
            chk1 ("fill_wr", mem_wr, 1'b0);
            chk16("fill_addr", mem_addr, 16'h1230 + 16'(2 * k));
        end
        for (int n = 0; n < 6; n++) begin
            step(); i_rd = 1'b0; d_rd = 1'b1; d_wr = 1'b1; d_addr = 16'h5555; #1;
            chk1 ("iso_en", mem_enable, 1'b0);
            chk1 ("iso_wr", mem_wr, 1'b0);
            chk16("iso_addr", mem_addr, 16'h123E);
        end
        step(); stray = 1'b1; d_rd = 1'b0; d_wr = 1'b0; #1;
        chk1("stray_i", i_data_valid, 1'b0);
        chk1("stray_d", d_data_valid, 1'b0);
        step(); stray = 1'b0; i_req = 1'b0; #1;
        chk1("i_rel_busy", arb_busy, 1'b1);
        step(); #1;
        chk1("i_idle_busy", arb_busy, 1'b0);
        chk1("i_idle_gnt", i_grant, 1'b0);

        // Single-word write-through
        step(); d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h00F0; d_wdata = 16'hBEEF; #1;
        chk1("wt_gnt0", d_grant, 1'b0);
        chk1("wt_en0", mem_enable, 1'b0);
        step(); #1;
        chk1 ("wt_gnt", d_grant, 1'b1);
        chk1 ("wt_en", mem_enable, 1'b1);
        chk1 ("wt_wr", mem_wr, 1'b1);
        chk16("wt_addr", mem_addr, 16'h00F0);
        chk16("wt_data", mem_wdata, 16'hBEEF);
        step(); d_req = 1'b0; d_wr = 1'b0; #1;
        chk1("wt_en1", mem_enable, 1'b0);
        chk1("wt_busy1", arb_busy, 1'b1);
        step(); #1;
        chk1("wt_busy2", arb_busy, 1'b0);

        // Reset in the middle of an I fill with reads in flight
        step(); i_req = 1'b1;
        step(); i_rd = 1'b1; i_addr = 16'h2000; #1;
        chk1("rm_gnt", i_grant, 1'b1);
        step(); i_addr = 16'h2002;
        step(); i_addr = 16'h2004;
        #2 rst = 1'b1;
        #1 chk_all_zero("rst_mid");
        i_req = 1'b0; i_rd = 1'b0;
        step(); step(); rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step(); #1;
            chk1("post_rst_en", mem_enable, 1'b0);
        end

        // Tie from reset: D first, then I after one bubble
        step(); i_req = 1'b1; d_req = 1'b1; #1;
        chk1("tie1_gnt0", d_grant | i_grant, 1'b0);
        step(); d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1111; #1;
        chk1("tie1_d", d_grant, 1'b1);
        chk1("tie1_noti", i_grant, 1'b0);
        step(); d_req = 1'b0; d_wr = 1'b0; #1;
        chk1("tie1_d_hold", d_grant, 1'b1);
        step(); #1;
        chk1("tie1_bubble", arb_busy, 1'b0);
        chk1("tie1_bub_i", i_grant, 1'b0);
        step(); #1;
        chk1("tie1_i", i_grant, 1'b1);
        step(); i_req = 1'b0;
        step(); #1;
        chk1("tie1_end", arb_busy, 1'b0);

        // D alone, so the next tie must go to I
        step(); d_req = 1'b1;
        step(); #1;
        chk1("d_alone", d_grant, 1'b1);
        step(); d_req = 1'b0;
        step(); #1;
        chk1("d_alone_end", arb_busy, 1'b0);
        step(); i_req = 1'b1; d_req = 1'b1;
        step(); #1;
        chk1("tie2_i", i_grant, 1'b1);
        chk1("tie2_notd", d_grant, 1'b0);
        step(); i_req = 1'b0;
        step(); #1;
        chk1("tie2_bubble", arb_busy, 1'b0);
        step(); #1;
        chk1("tie2_d", d_grant, 1'b1);

        // D fill that drops its request with reads outstanding, I waiting
        for (int k = 0; k < 3; k++) begin
            step(); d_rd = 1'b1; d_addr = 16'h3000 + 16'(k);
            expect_ret(1'b1);
            #1;
            chk1 ("dr_en", mem_enable, 1'b1);
            chk16("dr_addr", mem_addr, 16'h3000 + 16'(k));
        end
        step(); d_rd = 1'b0; d_req = 1'b0; i_req = 1'b1; #1;
        chk1("dr_drop_gnt", d_grant, 1'b1);
        chk1("dr_drop_en", mem_enable, 1'b0);
        for (int n = 0; n < 3; n++) begin
            step(); d_rd = 1'b1; d_wr = 1'b1; #1;
            chk1("drain_dgnt", d_grant, 1'b1);
            chk1("drain_igrant", i_grant, 1'b0);
            chk1("drain_en", mem_enable, 1'b0);
            chk1("drain_busy", arb_busy, 1'b1);
        end
        step(); d_rd = 1'b0; d_wr = 1'b0; #1;
        chk1("drain_idle_d", d_grant, 1'b0);
        chk1("drain_idle_i", i_grant, 1'b0);
        chk1("drain_idle_busy", arb_busy, 1'b0);
        step(); #1;
        chk1("drain_then_i", i_grant, 1'b1);
        step(); i_req = 1'b0;
        step(); #1;
        chk1("final_idle", arb_busy, 1'b0);

        repeat (6) step();
        vectors++;
        assert (sb.size() == 0) else begin
            miscompares++;
            $error("FAIL sb_empty observed=%0d expected=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
